// File: rtl/intr_handshake_ctrl.sv
// Multi-channel interrupt handshake controller: arbitrates NCH level requests,
// runs a counter-enable phase, then an acknowledge handshake with timeout abort.
module intr_handshake_ctrl #(
    parameter int NCH     = 4,
    parameter int CNTW    = 4,
    parameter int TIMEOUT = 12,
    parameter bit RR_EN   = 1'b0
) (
    input  logic                                       clock,
    input  logic                                       RESET_G,
    input  logic [NCH-1:0]                             REQ,
    input  logic                                       CONT_EQL,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]   GNT_SEL,
    output logic [NCH-1:0]                             USCITE,
    output logic                                       GNT_VLD,
    output logic                                       ENABLE_COUNT,
    output logic                                       ACKOUT,
    output logic                                       TO_ERR,
    output logic                                       BUSY
);

    localparam int              SELW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT - 1);
    localparam logic [SELW-1:0] LAST_RST = SELW'(NCH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_ENIN = 3'd2,
        S_ACK  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] gnt_idx, gnt_nxt;
    logic [SELW-1:0] last_idx, last_nxt;
    logic [SELW-1:0] win_idx;
    logic [SELW-1:0] scan_idx;
    logic [CNTW-1:0] to_cnt, to_cnt_nxt;
    logic            err_flag, err_nxt;
    logic            req_gnt;

    assign req_gnt = REQ[gnt_idx];

    // Winner search: scanning from the farthest candidate to the nearest lets
    // the highest-priority set request overwrite all others.
    always_comb begin
        win_idx  = '0;
        scan_idx = '0;
        if (RR_EN) begin
            for (int off = NCH; off >= 1; off--) begin
                scan_idx = SELW'((int'(last_idx) + off) % NCH);
                if (REQ[scan_idx]) win_idx = scan_idx;
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (REQ[i]) win_idx = SELW'(i);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt_idx;
        last_nxt   = last_idx;
        to_cnt_nxt = to_cnt;
        err_nxt    = err_flag;
        case (state)
            S_IDLE: begin
                if (|REQ) state_nxt = S_ARB;
            end
            S_ARB: begin
                if (REQ == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    gnt_nxt   = win_idx;
                    state_nxt = S_ENIN;
                end
            end
            S_ENIN: begin
                if (!req_gnt) begin
                    state_nxt = S_IDLE;
                    gnt_nxt   = '0;
                end else if (CONT_EQL) begin
                    state_nxt  = S_ACK;
                    to_cnt_nxt = '0;
                end
            end
            S_ACK: begin
                to_cnt_nxt = to_cnt + 1'b1;
                // A request drop wins over a coincident timeout.
                if (!req_gnt) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b0;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                end
            end
            S_DONE: begin
                last_nxt  = gnt_idx;
                gnt_nxt   = '0;
                err_nxt   = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
                err_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (RESET_G) begin
            state    <= S_IDLE;
            gnt_idx  <= '0;
            last_idx <= LAST_RST;
            to_cnt   <= '0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt_idx  <= gnt_nxt;
            last_idx <= last_nxt;
            to_cnt   <= to_cnt_nxt;
            err_flag <= err_nxt;
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign BUSY         = (state != S_IDLE);
    assign GNT_VLD      = (state == S_ENIN) || (state == S_ACK);
    assign ENABLE_COUNT = (state == S_ENIN);
    assign ACKOUT       = (state == S_ACK);
    assign TO_ERR       = (state == S_DONE) && err_flag;
    assign GNT_SEL      = GNT_VLD ? gnt_idx : '0;
    assign USCITE       = GNT_VLD ? (NCH'(1) << gnt_idx) : '0;

endmodule
